// File: rtl/ddram_wr_buffer_if.sv
// ddram_wr_buffer_if
//   DDRAM Avalon-MM write port bundle. This is the port between the write
//   buffer and the DDRAM controller.
//   master : the write buffer. It drives the request, address, data and byte
//            enables, and samples waitrequest.
//   slave  : the DDRAM controller. It drives waitrequest (DDRAM_BUSY).
// Signals:
//   DDRAM_CLK       port clock (a copy of the video clock)
//   DDRAM_BUSY      waitrequest
//   DDRAM_BURSTCNT  burst length (always 1)
//   DDRAM_ADDR      64-bit word address
//   DDRAM_DIN       write data
//   DDRAM_BE        byte enables
//   DDRAM_WE        write request
//   DDRAM_RD        read request (never used, tied low)
interface ddram_wr_buffer_if;
    logic        DDRAM_CLK;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;
    logic        DDRAM_RD;

    modport master (
        output DDRAM_CLK,
        output DDRAM_BURSTCNT,
        output DDRAM_ADDR,
        output DDRAM_DIN,
        output DDRAM_BE,
        output DDRAM_WE,
        output DDRAM_RD,
        input  DDRAM_BUSY
    );

    modport slave (
        input  DDRAM_CLK,
        input  DDRAM_BURSTCNT,
        input  DDRAM_ADDR,
        input  DDRAM_DIN,
        input  DDRAM_BE,
        input  DDRAM_WE,
        input  DDRAM_RD,
        output DDRAM_BUSY
    );
endinterface

// File: rtl/ddram_wr_buffer.sv
// ddram_wr_buffer
//   Write-side buffer between the rotator and the DDRAM Avalon-MM port.
//   Single-beat writes arrive without backpressure. They are queued in an
//   ordered FIFO and then issued through a one-entry output register under
//   waitrequest flow control. A write is lost only when both the FIFO and the
//   output register are full and nothing drains in that cycle. Each loss sets
//   a sticky overflow flag.
//
//   Optional feature macro: DDRAM_WR_MERGE_EN. When it is defined, a write to
//   the same address as the FIFO tail entry is folded into that entry at byte
//   granularity instead of taking a new slot.
//
// Parameters:
//   DEPTH_LOG2  FIFO depth is 2**DEPTH_LOG2. The output register adds one more.
// Ports:
//   CLK_VIDEO   video/DDRAM clock, rising edge
//   RESET_N     asynchronous active-low reset
//   in_we       one-cycle write strobe from the rotator
//   in_addr     64-bit word address
//   in_din      write data
//   in_be       byte enables
//   ddram       DDRAM write port (master side)
//   level       FIFO occupancy, excluding the output register
//   overflow    sticky drop flag
//   ovf_clr     synchronous clear of overflow (a simultaneous drop wins)
module ddram_wr_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK_VIDEO,
    input  logic                  RESET_N,
    input  logic                  in_we,
    input  logic [28:0]           in_addr,
    input  logic [63:0]           in_din,
    input  logic [7:0]            in_be,
    ddram_wr_buffer_if.master     ddram,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

    typedef struct packed {
        logic [28:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
    } wr_entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wr_entry_t             mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    wr_entry_t             or_q;
    logic                  or_vld;

    wr_entry_t in_ent;
    assign in_ent = '{addr: in_addr, din: in_din, be: in_be};

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic accept;        // OR handed to DDRAM on this edge
    logic or_free;       // OR can take a new entry on this edge
    logic fifo_nonempty;
    logic full;
    logic head_load;     // FIFO head moves into OR
    logic bypass;        // input goes straight into OR
    logic merge;         // input folded into the FIFO tail entry
    logic push_req;
    logic push;
    logic drop;

    assign accept        = or_vld & ~ddram.DDRAM_BUSY;
    assign or_free       = ~or_vld | accept;
    assign fifo_nonempty = (level != '0);
    assign full          = (level == FULL_LVL);
    assign head_load     = or_free & fifo_nonempty;
    // Bypass only when the FIFO is empty. This keeps arrival order intact.
    assign bypass        = or_free & ~fifo_nonempty & in_we;

`ifdef DDRAM_WR_MERGE_EN
    logic [DEPTH_LOG2-1:0] tail_ptr;
    wr_entry_t             tail_q;
    wr_entry_t             tail_merged;
    logic [63:0]           merged_din;
    logic                  tail_loading;

    assign tail_ptr = wr_ptr - 1'b1;
    assign tail_q   = mem[tail_ptr];

    // With a single entry queued, the tail is also the head. If that entry
    // leaves for OR this cycle, it must not be merged into, because OR
    // contents are never modified.
    assign tail_loading = head_load & (level == (DEPTH_LOG2+1)'(1));
    assign merge        = in_we & fifo_nonempty & ~tail_loading
                        & (tail_q.addr == in_addr);

    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign merged_din[8*i +: 8] = in_be[i] ? in_din[8*i +: 8]
                                               : tail_q.din[8*i +: 8];
    end

    assign tail_merged = '{addr: tail_q.addr,
                           din:  merged_din,
                           be:   tail_q.be | in_be};
`else
    assign merge = 1'b0;
`endif

    assign push_req = in_we & ~bypass & ~merge;
    // When the FIFO is full, the head leaving in the same cycle frees the slot.
    assign push     = push_req & (~full | head_load);
    assign drop     = push_req & full & ~head_load;

    // ------------------------------------------------------------------
    // Storage array (no reset: contents are qualified by level/pointers)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_VIDEO) begin
        if (push) begin
            mem[wr_ptr] <= in_ent;
        end
`ifdef DDRAM_WR_MERGE_EN
        if (merge) begin
            mem[tail_ptr] <= tail_merged;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, overflow, output register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            or_vld   <= 1'b0;
            or_q     <= '0;
        end else begin
            if (push)      wr_ptr <= wr_ptr + 1'b1;
            if (head_load) rd_ptr <= rd_ptr + 1'b1;

            if (push && !head_load)      level <= level + 1'b1;
            else if (head_load && !push) level <= level - 1'b1;

            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;

            // OR is loaded from the FIFO head first, then from the input.
            // Otherwise it empties. While OR is stalled it keeps its contents.
            if (or_free) begin
                if (head_load) begin
                    or_vld <= 1'b1;
                    or_q   <= mem[rd_ptr];
                end else if (bypass) begin
                    or_vld <= 1'b1;
                    or_q   <= in_ent;
                end else begin
                    or_vld <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // DDRAM port
    // ------------------------------------------------------------------
    assign ddram.DDRAM_CLK      = CLK_VIDEO;
    assign ddram.DDRAM_BURSTCNT = 8'd1;
    assign ddram.DDRAM_RD       = 1'b0;
    assign ddram.DDRAM_WE       = or_vld;
    assign ddram.DDRAM_ADDR     = or_q.addr;
    assign ddram.DDRAM_DIN      = or_q.din;
    assign ddram.DDRAM_BE       = or_q.be;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_or_stable: assert property (@(posedge CLK_VIDEO) disable iff (!RESET_N)
        (or_vld && ddram.DDRAM_BUSY) |=> (or_vld && $stable(or_q)));

    a_level_bound: assert property (@(posedge CLK_VIDEO) disable iff (!RESET_N)
        level <= FULL_LVL);

endmodule
